// File: rtl/gpr_pkg.sv
// Shared definitions for the GPR writeback arbiter slice: register-index and
// data widths, register count, arbitration pointer encoding and small helpers.
package gpr_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [NUM_REGS-1:0]  reg_vec_t;

    // Which port wins the next conflict when both requesters are valid.
    typedef enum logic {
        FAV_A = 1'b0,
        FAV_B = 1'b1
    } fav_e;

    // Register x0 is hardwired; any index other than zero is a real register.
    function automatic logic idx_nonzero(input reg_idx_t idx);
        return (idx != {REG_IDX_W{1'b0}});
    endfunction

    // One-hot mask selecting a single register of the busy vector.
    function automatic reg_vec_t idx_onehot(input reg_idx_t idx);
        reg_vec_t v;
        v      = {NUM_REGS{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-destination scoreboard for the GPR writeback path.
// Only compiled when GPR_WB_SCOREBOARD_EN is defined; the arbiter ties its
// hazard/error outputs to zero otherwise.
// A register is marked busy at issue and cleared when its writeback is
// accepted. A same-cycle retire and re-issue of one register is legal and
// leaves it busy (the set wins).
`ifdef GPR_WB_SCOREBOARD_EN
module gpr_scoreboard
    import gpr_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     set_en,
    input  reg_idx_t set_rd,
    input  logic     clr_en,
    input  reg_idx_t clr_rd,
    input  reg_idx_t chk_rs1,
    input  reg_idx_t chk_rs2,
    output logic     rs1_busy,
    output logic     rs2_busy,
    output logic     err
);

    reg_vec_t busy_r;
    reg_vec_t busy_nxt_s;
    reg_vec_t set_mask_s;
    reg_vec_t clr_mask_s;
    logic     err_r;
    logic     set_act_s;
    logic     clr_act_s;
    logic     set_err_s;
    logic     clr_err_s;

    // Decode set/clear events that touch a real register and flag protocol misuse.
    always_comb begin
        set_act_s = set_en & idx_nonzero(set_rd);
        clr_act_s = clr_en & idx_nonzero(clr_rd);
        if (set_act_s) begin
            set_mask_s = idx_onehot(set_rd);
        end else begin
            set_mask_s = {NUM_REGS{1'b0}};
        end
        if (clr_act_s) begin
            clr_mask_s = idx_onehot(clr_rd);
        end else begin
            clr_mask_s = {NUM_REGS{1'b0}};
        end
        // Re-issuing a register that retires in this same cycle is not an error.
        set_err_s = set_act_s & busy_r[set_rd] &
                    ~(clr_act_s & (clr_rd == set_rd));
        clr_err_s = clr_act_s & ~busy_r[clr_rd];
    end

    // Next busy vector: clear first, then set so a same-cycle set wins; x0 never busy.
    always_comb begin
        busy_nxt_s    = (busy_r & ~clr_mask_s) | set_mask_s;
        busy_nxt_s[0] = 1'b0;
    end

    // Busy vector and sticky error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {NUM_REGS{1'b0}};
            err_r  <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            err_r  <= err_r | set_err_s | clr_err_s;
        end
    end

    assign rs1_busy = busy_r[chk_rs1];
    assign rs2_busy = busy_r[chk_rs2];
    assign err      = err_r;

endmodule
`endif

// File: rtl/gpr_wb_arbiter.sv
// GPR writeback arbiter: merges the ALU (A) and load (B) writeback requesters
// onto the single register-file write port, one grant per cycle, with a
// one-cycle registered write.
// PRIO_B = 0: round-robin on conflict; PRIO_B = 1: B always wins.
// Optional feature macro GPR_WB_SCOREBOARD_EN adds the pending-register
// scoreboard (hazard query and sticky protocol-error flag).
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter bit PRIO_B = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    input  logic [REG_IDX_W-1:0] a_rd,
    input  logic [DATA_W-1:0]    a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [REG_IDX_W-1:0] b_rd,
    input  logic [DATA_W-1:0]    b_data,
    output logic                 b_ready,
    input  logic                 issue_set,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [REG_IDX_W-1:0] chk_rs1,
    input  logic [REG_IDX_W-1:0] chk_rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [REG_IDX_W-1:0] gpr_rd,
    output logic [DATA_W-1:0]    gpr_rrd,
    output logic                 gpr_we,
    output logic                 err
);

    fav_e     fav_r;
    fav_e     fav_nxt_s;
    logic     a_grant_s;
    logic     b_grant_s;
    logic     acc_s;
    reg_idx_t acc_rd_s;
    data_t    acc_data_s;
    logic     wr_s;
    logic     gpr_we_r;
    reg_idx_t gpr_rd_r;
    data_t    gpr_rrd_r;

    // Arbitration pointer register; after reset A wins the first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fav_r <= FAV_A;
        end else begin
            fav_r <= fav_nxt_s;
        end
    end

    // Grant decision and pointer update; nothing is granted while in reset.
    always_comb begin
        a_grant_s = 1'b0;
        b_grant_s = 1'b0;
        fav_nxt_s = fav_r;
        if (rst) begin
            a_grant_s = 1'b0;
            b_grant_s = 1'b0;
        end else if (a_valid && b_valid) begin
            if (PRIO_B || (fav_r == FAV_B)) begin
                b_grant_s = 1'b1;
            end else begin
                a_grant_s = 1'b1;
            end
        end else if (a_valid) begin
            a_grant_s = 1'b1;
        end else if (b_valid) begin
            b_grant_s = 1'b1;
        end else begin
            a_grant_s = 1'b0;
            b_grant_s = 1'b0;
        end
        // The loser of the most recent grant is favoured next.
        if (a_grant_s) begin
            fav_nxt_s = FAV_B;
        end else if (b_grant_s) begin
            fav_nxt_s = FAV_A;
        end else begin
            fav_nxt_s = fav_r;
        end
    end

    // Select the accepted request; an rd of x0 is accepted but never written.
    always_comb begin
        acc_s = a_grant_s | b_grant_s;
        if (b_grant_s) begin
            acc_rd_s   = b_rd;
            acc_data_s = b_data;
        end else begin
            acc_rd_s   = a_rd;
            acc_data_s = a_data;
        end
        wr_s = acc_s & idx_nonzero(acc_rd_s);
    end

    // Register-file write port: one-cycle latency, index/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpr_we_r  <= 1'b0;
            gpr_rd_r  <= {REG_IDX_W{1'b0}};
            gpr_rrd_r <= {DATA_W{1'b0}};
        end else begin
            gpr_we_r <= wr_s;
            if (wr_s) begin
                gpr_rd_r  <= acc_rd_s;
                gpr_rrd_r <= acc_data_s;
            end else begin
                gpr_rd_r  <= gpr_rd_r;
                gpr_rrd_r <= gpr_rrd_r;
            end
        end
    end

    assign a_ready = a_grant_s;
    assign b_ready = b_grant_s;
    assign gpr_we  = gpr_we_r;
    assign gpr_rd  = gpr_rd_r;
    assign gpr_rrd = gpr_rrd_r;

`ifdef GPR_WB_SCOREBOARD_EN
    gpr_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_set),
        .set_rd   (issue_rd),
        .clr_en   (acc_s),
        .clr_rd   (acc_rd_s),
        .chk_rs1  (chk_rs1),
        .chk_rs2  (chk_rs2),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .err      (err)
    );
`else
    // Without the scoreboard the issue and hazard-query inputs have no effect.
    logic unused_sb_s;
    assign unused_sb_s = ^{issue_set, issue_rd, chk_rs1, chk_rs2, acc_s};
    assign rs1_busy    = 1'b0;
    assign rs2_busy    = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Testbench for gpr_wb_arbiter. Two instances share all stimulus:
// index 0 is round-robin (PRIO_B=0), index 1 is B-priority (PRIO_B=1).
// Works with or without GPR_WB_SCOREBOARD_EN.
module tb_gpr_wb_arbiter;

`ifdef GPR_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        a_valid, b_valid, issue_set;
    logic [4:0]  a_rd, b_rd, issue_rd, chk_rs1, chk_rs2;
    logic [31:0] a_data, b_data;

    logic        a_rdy [2];
    logic        b_rdy [2];
    logic        rs1_b [2];
    logic        rs2_b [2];
    logic        we    [2];
    logic        err_o [2];
    logic [4:0]  grd   [2];
    logic [31:0] grrd  [2];

    int checks = 0;
    int errors = 0;

    gpr_wb_arbiter #(.PRIO_B(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_rdy[0]),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_rdy[0]),
        .issue_set(issue_set), .issue_rd(issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .rs1_busy(rs1_b[0]), .rs2_busy(rs2_b[0]),
        .gpr_rd(grd[0]), .gpr_rrd(grrd[0]), .gpr_we(we[0]), .err(err_o[0])
    );

    gpr_wb_arbiter #(.PRIO_B(1'b1)) u_pb (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_rdy[1]),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_rdy[1]),
        .issue_set(issue_set), .issue_rd(issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .rs1_busy(rs1_b[1]), .rs2_busy(rs2_b[1]),
        .gpr_rd(grd[1]), .gpr_rrd(grrd[1]), .gpr_we(we[1]), .err(err_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        a_valid = 1'b0; b_valid = 1'b0; issue_set = 1'b0;
        a_rd = 5'd0; b_rd = 5'd0; issue_rd = 5'd0;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0;
        a_data = 32'd0; b_data = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_set = 1'b1;
        issue_rd  = rd;
        tick();
        issue_set = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (we[k] !== 1'b0 || grd[k] !== 5'd0 || grrd[k] !== 32'd0 || err_o[k] !== 1'b0 ||
                a_rdy[k] !== 1'b0 || b_rdy[k] !== 1'b0 || rs1_b[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst%0d: we=%b rd=%0d rrd=%h err=%b ar=%b br=%b rs1=%b, want all 0",
                         k, we[k], grd[k], grrd[k], err_o[k], a_rdy[k], b_rdy[k], rs1_b[k]);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (a_rdy[0] !== 1'b1 || b_rdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_ptr_favours_a: a_ready=%b b_ready=%b, want 1 0", a_rdy[0], b_rdy[0]);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_single_a();
        idle_inputs();
        issue(5'd5);
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h0000_1234;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (a_rdy[k] !== 1'b1 || b_rdy[k] !== 1'b0) begin
                errors++;
                $display("FAIL single_a_ready inst%0d: a_ready=%b b_ready=%b, want 1 0", k, a_rdy[k], b_rdy[k]);
            end
        end
        tick();
        a_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (we[k] !== 1'b1 || grd[k] !== 5'd5 || grrd[k] !== 32'h0000_1234 || err_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL single_a_write inst%0d: we=%b rd=%0d rrd=%h err=%b, want 1 5 00001234 0",
                         k, we[k], grd[k], grrd[k], err_o[k]);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (we[k] !== 1'b0 || grd[k] !== 5'd5 || grrd[k] !== 32'h0000_1234) begin
                errors++;
                $display("FAIL idle_hold inst%0d: we=%b rd=%0d rrd=%h, want 0 5 00001234",
                         k, we[k], grd[k], grrd[k]);
            end
        end
    endtask

    task automatic test_alternate();
        logic [4:0] exp_rd;
        idle_inputs();
        do_reset();
        for (int i = 0; i < 4; i++) issue(5'(10 + i));
        for (int i = 0; i < 4; i++) issue(5'(20 + i));
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            a_rd = 5'(10 + i); b_rd = 5'(20 + i);
            a_data = 32'hA000_0000 + 32'(i); b_data = 32'hB000_0000 + 32'(i);
            #1;
            checks++;
            if (a_rdy[0] !== ((i % 2) == 0) || b_rdy[0] !== ((i % 2) == 1)) begin
                errors++;
                $display("FAIL rr_grant cycle%0d: a_ready=%b b_ready=%b, want %b %b",
                         i, a_rdy[0], b_rdy[0], (i % 2) == 0, (i % 2) == 1);
            end
            checks++;
            if (a_rdy[1] !== 1'b0 || b_rdy[1] !== 1'b1) begin
                errors++;
                $display("FAIL prio_b_grant cycle%0d: a_ready=%b b_ready=%b, want 0 1", i, a_rdy[1], b_rdy[1]);
            end
            exp_rd = ((i % 2) == 0) ? 5'(10 + i) : 5'(20 + i);
            tick();
            checks++;
            if (we[0] !== 1'b1 || grd[0] !== exp_rd || we[1] !== 1'b1 || grd[1] !== 5'(20 + i) ||
                err_o[0] !== 1'b0 || err_o[1] !== 1'b0) begin
                errors++;
                $display("FAIL alt_write cycle%0d: rr we=%b rd=%0d pb we=%b rd=%0d, want 1 %0d 1 %0d",
                         i, we[0], grd[0], we[1], grd[1], exp_rd, 20 + i);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        chk_rs1 = 5'd7; chk_rs2 = 5'd8;
        issue_set = 1'b1; issue_rd = 5'd7;
        #1;
        checks++;
        if (rs1_b[0] !== 1'b0) begin
            errors++;
            $display("FAIL busy_before_edge: rs1_busy=%b, want 0", rs1_b[0]);
        end
        tick();
        issue_set = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rs1_b[k] !== SB || rs2_b[k] !== 1'b0) begin
                errors++;
                $display("FAIL busy_set inst%0d: rs1=%b rs2=%b, want %b 0", k, rs1_b[k], rs2_b[k], SB);
            end
        end
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hCAFE_0007;
        #1;
        checks++;
        if (b_rdy[0] !== 1'b1 || b_rdy[1] !== 1'b1) begin
            errors++;
            $display("FAIL b_alone_ready: %b %b, want 1 1", b_rdy[0], b_rdy[1]);
        end
        tick();
        b_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rs1_b[k] !== 1'b0 || we[k] !== 1'b1 || grd[k] !== 5'd7 || grrd[k] !== 32'hCAFE_0007 ||
                err_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL busy_clear inst%0d: rs1=%b we=%b rd=%0d rrd=%h err=%b, want 0 1 7 cafe0007 0",
                         k, rs1_b[k], we[k], grd[k], grrd[k], err_o[k]);
            end
        end
    endtask

    task automatic test_rd_zero();
        idle_inputs();
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (a_rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL rd0_ready: a_ready=%b, want 1", a_rdy[0]);
        end
        tick();
        a_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (we[k] !== 1'b0 || err_o[k] !== 1'b0 || grd[k] !== 5'd7 || rs1_b[k] !== 1'b0) begin
                errors++;
                $display("FAIL rd0_discard inst%0d: we=%b err=%b rd=%0d rs1=%b, want 0 0 7 0",
                         k, we[k], err_o[k], grd[k], rs1_b[k]);
            end
        end
    endtask

    task automatic test_same_cycle();
        idle_inputs();
        chk_rs1 = 5'd9;
        issue(5'd9);
        issue_set = 1'b1; issue_rd = 5'd9;
        a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h0000_0909;
        tick();
        issue_set = 1'b0; a_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rs1_b[k] !== SB || err_o[k] !== 1'b0 || we[k] !== 1'b1 || grd[k] !== 5'd9) begin
                errors++;
                $display("FAIL set_wins inst%0d: rs1=%b err=%b we=%b rd=%0d, want %b 0 1 9",
                         k, rs1_b[k], err_o[k], we[k], grd[k], SB);
            end
        end
        issue(5'd9);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (err_o[k] !== SB) begin
                errors++;
                $display("FAIL double_issue_err inst%0d: err=%b, want %b", k, err_o[k], SB);
            end
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        issue(5'd5);
        issue(5'd6);
        chk_rs2 = 5'd6;
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h5555_0005;
        tick();
        checks++;
        if (we[0] !== 1'b1 || rs2_b[0] !== SB || err_o[0] !== SB) begin
            errors++;
            $display("FAIL pre_reset: we=%b rs2=%b err=%b, want 1 %b %b", we[0], rs2_b[0], err_o[0], SB, SB);
        end
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (we[k] !== 1'b0 || grd[k] !== 5'd0 || grrd[k] !== 32'd0 || rs2_b[k] !== 1'b0 ||
                err_o[k] !== 1'b0 || a_rdy[k] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset inst%0d: we=%b rd=%0d rrd=%h rs2=%b err=%b ar=%b, want all 0",
                         k, we[k], grd[k], grrd[k], rs2_b[k], err_o[k], a_rdy[k]);
            end
        end
        tick();
        a_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (we[0] !== 1'b0 || we[1] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_no_write: we=%b %b, want 0 0", we[0], we[1]);
        end
    endtask

    task automatic test_random();
        bit [31:0]   m_busy [2];
        bit          m_err  [2];
        bit          m_we   [2];
        logic [4:0]  m_rd   [2];
        logic [31:0] m_data [2];
        bit          last_b [2];
        bit          ga, gb;
        logic [4:0]  rd_acc;
        logic [31:0] d_acc;
        bit          exp1, exp2;
        idle_inputs();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 32'd0; m_err[k] = 1'b0; m_we[k] = 1'b0;
            m_rd[k] = 5'd0; m_data[k] = 32'd0; last_b[k] = 1'b1;
        end
        for (int n = 0; n < 400; n++) begin
            a_valid   = 1'($urandom_range(0, 1));
            b_valid   = 1'($urandom_range(0, 1));
            a_rd      = 5'($urandom_range(0, 7));
            b_rd      = 5'($urandom_range(0, 7));
            a_data    = $urandom;
            b_data    = $urandom;
            issue_set = ($urandom_range(0, 9) < 3);
            issue_rd  = 5'($urandom_range(0, 7));
            chk_rs1   = 5'($urandom_range(0, 7));
            chk_rs2   = 5'($urandom_range(0, 7));
            #1;
            for (int k = 0; k < 2; k++) begin
                if (a_valid && b_valid) begin
                    gb = (k == 1) || !last_b[k];
                    ga = !gb;
                end else begin
                    ga = a_valid;
                    gb = b_valid;
                end
                checks++;
                if (a_rdy[k] !== ga || b_rdy[k] !== gb) begin
                    errors++;
                    $display("FAIL rnd_grant n%0d inst%0d: a_ready=%b b_ready=%b, want %b %b",
                             n, k, a_rdy[k], b_rdy[k], ga, gb);
                end
                exp1 = SB && m_busy[k][chk_rs1];
                exp2 = SB && m_busy[k][chk_rs2];
                checks++;
                if (rs1_b[k] !== exp1 || rs2_b[k] !== exp2) begin
                    errors++;
                    $display("FAIL rnd_busy n%0d inst%0d: rs1=%b rs2=%b, want %b %b",
                             n, k, rs1_b[k], rs2_b[k], exp1, exp2);
                end
                rd_acc = gb ? b_rd : a_rd;
                d_acc  = gb ? b_data : a_data;
                if (ga || gb) last_b[k] = gb;
                m_we[k] = (ga || gb) && (rd_acc != 5'd0);
                if (m_we[k]) begin
                    m_rd[k]   = rd_acc;
                    m_data[k] = d_acc;
                end
                if (SB) begin
                    if (m_we[k]) begin
                        if (!m_busy[k][rd_acc]) m_err[k] = 1'b1;
                        m_busy[k][rd_acc] = 1'b0;
                    end
                    if (issue_set && issue_rd != 5'd0) begin
                        if (m_busy[k][issue_rd]) m_err[k] = 1'b1;
                        m_busy[k][issue_rd] = 1'b1;
                    end
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (we[k] !== m_we[k] || grd[k] !== m_rd[k] || grrd[k] !== m_data[k] || err_o[k] !== m_err[k]) begin
                    errors++;
                    $display("FAIL rnd_write n%0d inst%0d: we=%b rd=%0d rrd=%h err=%b, want %b %0d %h %b",
                             n, k, we[k], grd[k], grrd[k], err_o[k], m_we[k], m_rd[k], m_data[k], m_err[k]);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_a();
        test_alternate();
        test_scoreboard();
        test_rd_zero();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 SHALL have parameter PRIO_B, default 0; 0 = round-robin between ports A and B, 1 = port B always wins.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have ports a_valid in 1, a_rd in 5, a_data in 32, a_ready out 1: ALU writeback requester.
REQ-005 SHALL have ports b_valid in 1, b_rd in 5, b_data in 32, b_ready out 1: load writeback requester.
REQ-006 SHALL have ports issue_set in 1, issue_rd in 5: marks a destination register pending at issue.
REQ-007 SHALL have ports chk_rs1 in 5, chk_rs2 in 5, rs1_busy out 1, rs2_busy out 1: hazard query.
REQ-008 SHALL have ports gpr_rd out 5, gpr_rrd out 32, gpr_we out 1: drive the register-file write port.
REQ-009 SHALL have port err out 1: sticky protocol-error flag.

Function
REQ-010 SHALL accept a request (handshake) in any cycle where its valid and ready are both high.
REQ-011 SHALL derive a_ready and b_ready combinationally from the valids and the arbitration state, granting at most one port per cycle.
REQ-012 SHALL, with exactly one valid high, grant that port.
REQ-013 SHALL, with both valid and PRIO_B=0, grant the port not granted most recently; the last-grant pointer updates on every grant.
REQ-014 SHALL, with both valid and PRIO_B=1, grant B.
REQ-015 SHALL register an accepted request into gpr_rd/gpr_rrd/gpr_we, so gpr_we is high in the cycle after acceptance (latency 1).
REQ-016 SHALL drive gpr_we low in a cycle that follows no acceptance; gpr_rd and gpr_rrd then hold their last values.
REQ-017 SHALL accept a request with rd=0 and discard it: gpr_we stays low and busy is unaffected.
REQ-018 SHALL never assert gpr_we with gpr_rd=0.
REQ-019 SHALL keep a 32-bit busy vector; bit 0 is constant 0.
REQ-020 SHALL set busy[issue_rd] at the clock edge where issue_set=1 and issue_rd!=0.
REQ-021 SHALL clear busy[rd] at the clock edge where a request with that rd is accepted, so the following cycle reads the forwarded value.
REQ-022 SHALL apply the set when a set and a clear target the same register in the same cycle.
REQ-023 SHALL drive rs1_busy = busy[chk_rs1] and rs2_busy = busy[chk_rs2] combinationally from the registered vector.
REQ-024 SHALL set err when issue_set targets an already-busy nonzero register or when a nonzero-rd request is accepted for a non-busy register; err holds until reset.

Reset
REQ-025 SHALL, during reset, hold gpr_we=0, gpr_rd=0, gpr_rrd=0, busy=0, err=0, and the pointer favouring A next.
REQ-026 SHALL, when reset asserts mid-operation, drop any accepted but not-yet-written request with no write issued.
REQ-027 SHALL keep a_ready and b_ready low while rst is high.

Configuration
REQ-028 SHALL, with macro GPR_WB_SCOREBOARD_EN defined, implement REQ-019..REQ-024.
REQ-029 SHALL, with GPR_WB_SCOREBOARD_EN undefined, omit the busy vector: rs1_busy=rs2_busy=err=0 constant, and issue_* and chk_* are ignored.

Structure
REQ-030 SHALL place the register-index width (5), data width (32) and register count (32) in shared package gpr_pkg.
REQ-031 SHALL implement the scoreboard as sub-module gpr_scoreboard (set/clear/query/err); the arbiter and output register stay in the top module.

Verification
REQ-032 SHALL cover: a_valid=1, a_rd=5, a_data=0x1234 alone -> a_ready=1 same cycle; next cycle gpr_we=1, gpr_rd=5, gpr_rrd=0x1234.
REQ-033 SHALL cover: both valid for 4 cycles, PRIO_B=0 -> grants A,B,A,B; PRIO_B=1 -> B every cycle, a_ready=0.
REQ-034 SHALL cover: issue_set with issue_rd=7, then chk_rs1=7 -> rs1_busy=1; accept b_rd=7 -> rs1_busy=0 the next cycle.
REQ-035 SHALL cover: a_rd=0 accepted -> a_ready=1, gpr_we=0 next cycle, err=0.
REQ-036 SHALL cover: same cycle issue_set with issue_rd=9 and accept a_rd=9 while busy[9]=1 -> busy[9]=1 afterwards; a second issue_set with issue_rd=9 -> err=1.
REQ-037 SHALL cover: rst pulsed asynchronously in the cycle after an accept -> gpr_we=0 immediately and busy=0.
